// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - Iterative RV32M multiply/divide unit for the execute stage
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, funct3     M-extension op valid and selector from the decode/execute register
//   rs1_data,rs2_data operands A and B
//   rd_index          destination register of the op
//   flush             abort the current op (branch taken / exception)
//   stall             hold upstream pipeline registers while the unit is busy
//   done              result valid, exactly one cycle
//   result            computed value, held until the next completion
//   rd_index_out      destination of result, held alongside it
//
// Build option: define MULDIV_SINGLE_CYCLE_MUL_EN to replace the iterative
// multiplier with a combinational one (MUL-class ops complete one cycle after
// start). Divide behaviour is the same in both builds.

module ex_muldiv #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             funct3,
  input  logic [XLEN-1:0]        rs1_data,
  input  logic [XLEN-1:0]        rs2_data,
  input  logic [RFIDX_WIDTH-1:0] rd_index,
  input  logic                   flush,
  output logic                   stall,
  output logic                   done,
  output logic [XLEN-1:0]        result,
  output logic [RFIDX_WIDTH-1:0] rd_index_out
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]          count_q;
  logic [2:0]             funct3_q;
  logic [RFIDX_WIDTH-1:0] rd_q;
  logic                   neg_q;      // negate product / quotient at the end
  logic                   rem_neg_q;  // remainder follows the dividend sign
  logic [2*XLEN-1:0]      a_q;        // multiplicand, shifted left each step
  logic [XLEN-1:0]        b_q;        // multiplier (shifted right) or divisor
  logic [2*XLEN-1:0]      acc_q;      // product, or {remainder, quotient}
  logic [XLEN-1:0]        result_q;
  logic [RFIDX_WIDTH-1:0] rd_out_q;

  // Operand decode, evaluated in the start cycle
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic            accept;
  logic            last_iter;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] special_res;

  always_comb begin
    is_div   = funct3[2];
    a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    a_neg    = a_signed && rs1_data[XLEN-1];
    b_neg    = b_signed && rs2_data[XLEN-1];
    a_mag    = a_neg ? -rs1_data : rs1_data;
    b_mag    = b_neg ? -rs2_data : rs2_data;
    div_zero = is_div && (rs2_data == '0);
    // Only the signed forms (DIV/REM, funct3[0]=0) can overflow
    div_ovf  = is_div && !funct3[0] &&
               (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_data);
    special  = div_zero || div_ovf;
    if (div_zero) begin
      special_res = funct3[1] ? rs1_data : '1;
    end else begin
      special_res = funct3[1] ? '0 : rs1_data;
    end
  end

  assign accept    = (state_q == ST_IDLE) && start && !flush;
  assign last_iter = (count_q == CW'(XLEN - 1));

  // One iteration of shift-add multiply and of restoring divide
  logic [2*XLEN-1:0] mul_acc_nxt;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   rem_nxt;
  logic [XLEN-1:0]   quo_nxt;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    mul_acc_nxt = acc_q + (b_q[0] ? a_q : '0);
    prod_fix    = neg_q ? -mul_acc_nxt : mul_acc_nxt;

    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    // When div_ge holds the difference is below the divisor, so XLEN bits suffice
    div_diff  = div_shift[XLEN-1:0] - b_q;
    rem_nxt   = div_ge ? div_diff : div_shift[XLEN-1:0];
    quo_nxt   = {acc_q[XLEN-2:0], div_ge};
    quo_fix   = neg_q ? -quo_nxt : quo_nxt;
    rem_fix   = rem_neg_q ? -rem_nxt : rem_nxt;

    if (funct3_q[2]) begin
      final_res = funct3_q[1] ? rem_fix : quo_fix;
    end else begin
      final_res = (funct3_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
  end

`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
  // Sign-extending by the effective sign makes a plain 2*XLEN product exact
  // for every signed/unsigned combination.
  logic [2*XLEN-1:0] sc_a;
  logic [2*XLEN-1:0] sc_b;
  logic [2*XLEN-1:0] sc_prod;
  logic [XLEN-1:0]   sc_res;

  always_comb begin
    sc_a    = {{XLEN{a_neg}}, rs1_data};
    sc_b    = {{XLEN{b_neg}}, rs2_data};
    sc_prod = sc_a * sc_b;
    sc_res  = (funct3[1:0] == 2'd0) ? sc_prod[XLEN-1:0] : sc_prod[2*XLEN-1:XLEN];
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (special) begin
            state_d = ST_DONE;
          end else if (is_div) begin
            state_d = ST_DIV;
          end else begin
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
            state_d = ST_DONE;
`else
            state_d = ST_MUL;
`endif
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (last_iter) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            funct3_q  <= funct3;
            rd_q      <= rd_index;
            count_q   <= '0;
            b_q       <= b_mag;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            if (is_div) begin
              a_q   <= '0;
              acc_q <= {{XLEN{1'b0}}, a_mag};
            end else begin
              a_q   <= {{XLEN{1'b0}}, a_mag};
              acc_q <= '0;
            end
            if (special) begin
              result_q <= special_res;
              rd_out_q <= rd_index;
            end
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
            else if (!is_div) begin
              result_q <= sc_res;
              rd_out_q <= rd_index;
            end
`endif
          end
        end
        ST_MUL: begin
          if (!flush) begin
            acc_q   <= mul_acc_nxt;
            a_q     <= a_q << 1;
            b_q     <= b_q >> 1;
            count_q <= count_q + CW'(1);
            if (last_iter) begin
              result_q <= final_res;
              rd_out_q <= rd_q;
            end
          end
        end
        ST_DIV: begin
          if (!flush) begin
            acc_q   <= {rem_nxt, quo_nxt};
            count_q <= count_q + CW'(1);
            if (last_iter) begin
              result_q <= final_res;
              rd_out_q <= rd_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Stall is combinational so the pipeline freezes in the start cycle itself
  assign stall        = accept || (state_q == ST_MUL) || (state_q == ST_DIV);
  assign done         = (state_q == ST_DONE) && !flush;
  assign result       = result_q;
  assign rd_index_out = rd_out_q;

endmodule
